// File: rtl/map_renderer.sv
// Tile-map pixel renderer: three-stage pipeline from VGA coordinates to registered RGB,
// reading a per-frame shadow copy of the game map with player overlay and game-over dimming.
module map_renderer (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         frame_start,
    input  logic [299:0] map_1d,
    input  logic [9:0]   playerX,
    input  logic [9:0]   playerY,
    input  logic         over,
    input  logic [9:0]   DrawX,
    input  logic [9:0]   DrawY,
    output logic [7:0]   Red,
    output logic [7:0]   Green,
    output logic [7:0]   Blue,
    output logic         pix_valid
);

    localparam logic [23:0] PLAYER_RGB = 24'h0040FF;

    function automatic logic [3:0] row_of(input logic [9:0] y);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 1; i < 10; i++) begin
            if (y >= 10'(48 * i)) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic [23:0] tile_rgb(input logic [2:0] code,
                                             input logic       wave_alt,
                                             input logic       bomb_alt);
        logic [23:0] c;
        case (code)
            3'd0:    c = 24'h008000;
            3'd1:    c = wave_alt ? 24'hFFFF00 : 24'hFFA000;
            3'd2:    c = 24'hA000A0;
            3'd3:    c = 24'h606060;
            3'd4:    c = 24'hB05020;
            3'd5:    c = bomb_alt ? 24'hFFFFFF : 24'h000000;
            default: c = 24'hFF00FF;
        endcase
        return c;
    endfunction

    function automatic logic [23:0] dim(input logic [23:0] c);
        return {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
    endfunction

    logic [299:0] shadow_q, shadow_d;
    logic         over_q, over_d;
    logic [4:0]   frame_cnt_q, frame_cnt_d;

    logic [9:0]   x_p1_q, x_p1_d, y_p1_q, y_p1_d;
    logic [9:0]   px_p1_q, px_p1_d, py_p1_q, py_p1_d;
    logic [3:0]   col_p1_q, col_p1_d, row_p1_q, row_p1_d;
    logic         vld_p1_q, vld_p1_d;

    logic [2:0]   code_p2_q, code_p2_d;
    logic         hit_p2_q, hit_p2_d;
    logic         vld_p2_q, vld_p2_d;

    logic [23:0]  rgb_p3_q, rgb_p3_d;
    logic         vld_p3_q, vld_p3_d;

    logic [6:0]   tile_idx;
    logic [8:0]   sh_amt;
    logic [10:0]  x_ext, y_ext, px_ext, py_ext;
    logic [23:0]  rgb_sel;

    always_comb begin
        // Frame-synchronous state only moves on frame_start.
        shadow_d    = frame_start ? map_1d : shadow_q;
        over_d      = frame_start ? over : over_q;
        frame_cnt_d = frame_start ? frame_cnt_q + 5'd1 : frame_cnt_q;

        // S1: capture coordinates, player position, tile indices and activity.
        x_p1_d   = DrawX;
        y_p1_d   = DrawY;
        px_p1_d  = playerX;
        py_p1_d  = playerY;
        col_p1_d = DrawX[9:6];
        row_p1_d = row_of(DrawY);
        vld_p1_d = (DrawX < 10'd640) && (DrawY < 10'd480);

        // S2: shadow-map lookup and player hit test in 11-bit space.
        tile_idx = 7'(col_p1_q) * 7'd10 + 7'(row_p1_q);
        sh_amt   = 9'd297 - 9'(tile_idx) * 9'd3;
        code_p2_d = 3'd0;
        if (vld_p1_q && col_p1_q < 4'd10) code_p2_d = 3'(shadow_q >> sh_amt);
        x_ext  = {1'b0, x_p1_q};
        y_ext  = {1'b0, y_p1_q};
        px_ext = {1'b0, px_p1_q};
        py_ext = {1'b0, py_p1_q};
        hit_p2_d = (x_ext >= px_ext) && (x_ext <= px_ext + 11'd63) &&
                   (y_ext >= py_ext) && (y_ext <= py_ext + 11'd47);
        vld_p2_d = vld_p1_q;

        // S3: colour, player overlay, then game-over dimming; blanking forces black.
        rgb_sel = hit_p2_q ? PLAYER_RGB : tile_rgb(code_p2_q, frame_cnt_q[2], frame_cnt_q[3]);
        if (over_q) rgb_sel = dim(rgb_sel);
        rgb_p3_d = vld_p2_q ? rgb_sel : 24'h000000;
        vld_p3_d = vld_p2_q;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            shadow_q    <= '0;
            over_q      <= 1'b0;
            frame_cnt_q <= '0;
            x_p1_q      <= '0;
            y_p1_q      <= '0;
            px_p1_q     <= '0;
            py_p1_q     <= '0;
            col_p1_q    <= '0;
            row_p1_q    <= '0;
            vld_p1_q    <= 1'b0;
            code_p2_q   <= '0;
            hit_p2_q    <= 1'b0;
            vld_p2_q    <= 1'b0;
            rgb_p3_q    <= '0;
            vld_p3_q    <= 1'b0;
        end else begin
            shadow_q    <= shadow_d;
            over_q      <= over_d;
            frame_cnt_q <= frame_cnt_d;
            x_p1_q      <= x_p1_d;
            y_p1_q      <= y_p1_d;
            px_p1_q     <= px_p1_d;
            py_p1_q     <= py_p1_d;
            col_p1_q    <= col_p1_d;
            row_p1_q    <= row_p1_d;
            vld_p1_q    <= vld_p1_d;
            code_p2_q   <= code_p2_d;
            hit_p2_q    <= hit_p2_d;
            vld_p2_q    <= vld_p2_d;
            rgb_p3_q    <= rgb_p3_d;
            vld_p3_q    <= vld_p3_d;
        end
    end

    assign Red       = rgb_p3_q[23:16];
    assign Green     = rgb_p3_q[15:8];
    assign Blue      = rgb_p3_q[7:0];
    assign pix_valid = vld_p3_q;

endmodule

// File: tb/tb_map_renderer.sv
// Directed bench for map_renderer: one task per scenario, expected colours hand-computed.
module tb_map_renderer;

    logic         Clk = 1'b0;
    logic         Reset = 1'b0;
    logic         frame_start = 1'b0;
    logic [299:0] map_1d = '0;
    logic [9:0]   playerX = 10'd1000;
    logic [9:0]   playerY = 10'd1000;
    logic         over = 1'b0;
    logic [9:0]   DrawX = '0;
    logic [9:0]   DrawY = '0;
    logic [7:0]   Red, Green, Blue;
    logic         pix_valid;

    int total = 0;
    int bad = 0;

    map_renderer dut (
        .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .map_1d(map_1d),
        .playerX(playerX), .playerY(playerY), .over(over),
        .DrawX(DrawX), .DrawY(DrawY),
        .Red(Red), .Green(Green), .Blue(Blue), .pix_valid(pix_valid)
    );

    always #5 Clk = ~Clk;

    task automatic set_tile(input int c, input int r, input logic [2:0] code);
        for (int k = 0; k < 3; k++) map_1d[299 - 3 * (10 * c + r) - k] = code[2 - k];
    endtask

    task automatic pulse_fs();
        @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
    endtask

    task automatic run_pix(input int x, input int y, output logic [23:0] rgb, output logic v);
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        repeat (3) @(posedge Clk);
        #1;
        rgb = {Red, Green, Blue};
        v = pix_valid;
    endtask

    task automatic test_reset();
        logic [23:0] rgb;
        logic v;
        map_1d = {100{3'd4}};
        pulse_fs();
        run_pix(0, 0, rgb, v);
        total++;
        if (rgb !== 24'h0 || v !== 1'b0)
            $display("FAIL reset_hold rgb=%h v=%b want rgb=000000 v=0", rgb, v);
        if (rgb !== 24'h0 || v !== 1'b0) bad++;
        @(negedge Clk);
        Reset = 1'b1;
        run_pix(130, 150, rgb, v);
        total++;
        if (rgb !== 24'h008000 || v !== 1'b1) begin
            bad++;
            $display("FAIL reset_empty rgb=%h v=%b want rgb=008000 v=1", rgb, v);
        end
        map_1d = '0;
    endtask

    task automatic test_tile_load();
        logic [23:0] rgb;
        logic v;
        set_tile(2, 3, 3'd4);
        pulse_fs();
        run_pix(130, 150, rgb, v);
        total++;
        if (rgb !== 24'hB05020 || v !== 1'b1) begin
            bad++;
            $display("FAIL tile_load rgb=%h v=%b want rgb=B05020 v=1", rgb, v);
        end
    endtask

    task automatic test_shadow();
        logic [23:0] rgb;
        logic v;
        set_tile(2, 3, 3'd0);
        set_tile(3, 3, 3'd3);
        run_pix(130, 150, rgb, v);
        total++;
        if (rgb !== 24'hB05020 || v !== 1'b1) begin
            bad++;
            $display("FAIL shadow_hold rgb=%h v=%b want rgb=B05020 v=1", rgb, v);
        end
        pulse_fs();
        run_pix(130, 150, rgb, v);
        total++;
        if (rgb !== 24'h008000 || v !== 1'b1) begin
            bad++;
            $display("FAIL shadow_reload rgb=%h v=%b want rgb=008000 v=1", rgb, v);
        end
    endtask

    task automatic test_player();
        int          xs [5] = '{191, 192, 127, 128, 128};
        int          ys [5] = '{191, 191, 191, 144, 143};
        logic [23:0] ex [5] = '{24'h0040FF, 24'h606060, 24'h008000, 24'h0040FF, 24'h008000};
        logic [23:0] rgb;
        logic v;
        playerX = 10'd128;
        playerY = 10'd144;
        for (int i = 0; i < 5; i++) begin
            run_pix(xs[i], ys[i], rgb, v);
            total++;
            if (rgb !== ex[i] || v !== 1'b1) begin
                bad++;
                $display("FAIL player(%0d,%0d) rgb=%h v=%b want rgb=%h v=1", xs[i], ys[i], rgb, v, ex[i]);
            end
        end
        playerX = 10'd1000;
        playerY = 10'd1000;
    endtask

    task automatic test_blink();
        // Per row: frame pulses before checking, then bomb (70,50) and wave (70,100) colours.
        int          pulses [4] = '{1, 5, 4, 4};
        logic [23:0] bomb   [4] = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
        logic [23:0] wave   [4] = '{24'hFFA000, 24'hFFA000, 24'hFFFF00, 24'hFFA000};
        int          sx [3] = '{0, 639, 320};
        int          sy [3] = '{0, 479, 240};
        logic [23:0] sex [3] = '{24'hA000A0, 24'hFF00FF, 24'hFF00FF};
        logic [23:0] rgb;
        logic v;
        set_tile(1, 1, 3'd5);
        set_tile(1, 2, 3'd1);
        set_tile(0, 0, 3'd2);
        set_tile(9, 9, 3'd6);
        set_tile(5, 5, 3'd7);
        for (int s = 0; s < 4; s++) begin
            repeat (pulses[s]) pulse_fs();
            run_pix(70, 50, rgb, v);
            total++;
            if (rgb !== bomb[s] || v !== 1'b1) begin
                bad++;
                $display("FAIL bomb_step%0d rgb=%h v=%b want rgb=%h v=1", s, rgb, v, bomb[s]);
            end
            run_pix(70, 100, rgb, v);
            total++;
            if (rgb !== wave[s] || v !== 1'b1) begin
                bad++;
                $display("FAIL wave_step%0d rgb=%h v=%b want rgb=%h v=1", s, rgb, v, wave[s]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            run_pix(sx[i], sy[i], rgb, v);
            total++;
            if (rgb !== sex[i] || v !== 1'b1) begin
                bad++;
                $display("FAIL code(%0d,%0d) rgb=%h v=%b want rgb=%h v=1", sx[i], sy[i], rgb, v, sex[i]);
            end
        end
    endtask

    task automatic test_over();
        int          xs [6] = '{400, 70, 400, 400, 700, 0};
        int          ys [6] = '{300, 100, 300, 300, 300, 480};
        int          pl [6] = '{1000, 1000, 384, 1000, 1000, 1000};
        logic [23:0] ex [6] = '{24'h004000, 24'h7F5000, 24'h00207F, 24'h004000, 24'h0, 24'h0};
        logic [23:0] rgb;
        logic v;
        logic ev;
        over = 1'b1;
        pulse_fs();
        over = 1'b0;
        for (int i = 0; i < 6; i++) begin
            playerX = 10'(pl[i]);
            playerY = (pl[i] == 384) ? 10'd288 : 10'd1000;
            ev = (xs[i] < 640) && (ys[i] < 480);
            run_pix(xs[i], ys[i], rgb, v);
            total++;
            if (rgb !== ex[i] || v !== ev) begin
                bad++;
                $display("FAIL over(%0d,%0d) rgb=%h v=%b want rgb=%h v=%b", xs[i], ys[i], rgb, v, ex[i], ev);
            end
        end
        playerX = 10'd1000;
        playerY = 10'd1000;
        pulse_fs();
        run_pix(400, 300, rgb, v);
        total++;
        if (rgb !== 24'h008000 || v !== 1'b1) begin
            bad++;
            $display("FAIL over_clear rgb=%h v=%b want rgb=008000 v=1", rgb, v);
        end
    endtask

    task automatic test_frame_boundary();
        logic [23:0] rgb;
        set_tile(2, 3, 3'd4);
        @(negedge Clk);
        DrawX = 10'd130;
        DrawY = 10'd150;
        repeat (4) @(posedge Clk);
        #1;
        rgb = {Red, Green, Blue};
        total++;
        if (rgb !== 24'h008000) begin
            bad++;
            $display("FAIL fb_before rgb=%h want 008000", rgb);
        end
        @(negedge Clk);
        frame_start = 1'b1;
        @(negedge Clk);
        frame_start = 1'b0;
        @(posedge Clk);
        #1;
        rgb = {Red, Green, Blue};
        total++;
        if (rgb !== 24'h008000) begin
            bad++;
            $display("FAIL fb_in_flight rgb=%h want 008000", rgb);
        end
        @(posedge Clk);
        #1;
        rgb = {Red, Green, Blue};
        total++;
        if (rgb !== 24'hB05020) begin
            bad++;
            $display("FAIL fb_after rgb=%h want B05020", rgb);
        end
    endtask

    task automatic test_back_to_back();
        int          xs [9] = '{0, 700, 70, 639, 400, 70, 639, 640, 130};
        int          ys [9] = '{0, 10, 100, 479, 300, 50, 480, 479, 150};
        logic [23:0] ex [9] = '{24'hA000A0, 24'h0, 24'hFFA000, 24'hFF00FF, 24'h008000,
                                24'h000000, 24'h0, 24'h0, 24'hB05020};
        logic [23:0] rgb;
        logic ev;
        for (int t = 0; t < 12; t++) begin
            @(negedge Clk);
            if (t >= 3) begin
                rgb = {Red, Green, Blue};
                ev = (xs[t-3] < 640) && (ys[t-3] < 480);
                total++;
                if (rgb !== ex[t-3] || pix_valid !== ev) begin
                    bad++;
                    $display("FAIL stream%0d rgb=%h v=%b want rgb=%h v=%b", t - 3, rgb, pix_valid, ex[t-3], ev);
                end
            end
            if (t < 9) begin
                DrawX = 10'(xs[t]);
                DrawY = 10'(ys[t]);
            end
        end
    endtask

    task automatic test_reset_midline();
        logic [23:0] rgb;
        logic v;
        @(negedge Clk);
        DrawX = 10'd0;
        DrawY = 10'd0;
        repeat (4) @(posedge Clk);
        #1;
        rgb = {Red, Green, Blue};
        total++;
        if (rgb !== 24'hA000A0 || pix_valid !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset rgb=%h v=%b want rgb=A000A0 v=1", rgb, pix_valid);
        end
        #2;
        Reset = 1'b0;
        #1;
        rgb = {Red, Green, Blue};
        total++;
        if (rgb !== 24'h0 || pix_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset rgb=%h v=%b want rgb=000000 v=0", rgb, pix_valid);
        end
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        rgb = {Red, Green, Blue};
        total++;
        if (rgb !== 24'h0 || pix_valid !== 1'b0) begin
            bad++;
            $display("FAIL refill_2 rgb=%h v=%b want rgb=000000 v=0", rgb, pix_valid);
        end
        @(posedge Clk);
        #1;
        rgb = {Red, Green, Blue};
        total++;
        if (rgb !== 24'h008000 || pix_valid !== 1'b1) begin
            bad++;
            $display("FAIL refill_3 rgb=%h v=%b want rgb=008000 v=1", rgb, pix_valid);
        end
        run_pix(70, 100, rgb, v);
        total++;
        if (rgb !== 24'h008000 || v !== 1'b1) begin
            bad++;
            $display("FAIL shadow_cleared rgb=%h v=%b want rgb=008000 v=1", rgb, v);
        end
    endtask

    initial begin
        test_reset();
        test_tile_load();
        test_shadow();
        test_player();
        test_blink();
        test_over();
        test_frame_boundary();
        test_back_to_back();
        test_reset_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
